mc_bus_sequencer: RTL and testbench
===================================

Name: mc_bus_sequencer

Overview:
- Parametrised multicycle phase sequencer for the MIPS core; successor to the fixed-latency control timing used today.
- Steps each instruction through IF/ID/EX/MEM/WB with a per-class path.
- Drives PC, IR, latch and register-file write enables.
- Talks to instruction and data memory over a req/ack handshake, so memories may have variable latency.
- Sits between the decoder (supplies instruction class) and the datapath latches.

Parameters:
- ADDR_W, 32, width of the memory address buses.
- DATA_W, 32, width of the instruction/data words.
- TO_CYCLES, 255, wait cycles allowed before timeout (used only with the optional feature).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-low.
- cls_i  in  3  instruction class from decoder; sampled in ID. 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 JAL, 6 HALT, 7 illegal.
- pc_i  in  ADDR_W  current PC from the PC register.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_ack  in  1  fetch complete.
- imem_rdata  in  DATA_W  fetched word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- ir_o  out  DATA_W  instruction register.
- pc_we  out  1  PC write enable.
- lat_we  out  1  datapath latch enable (A/B/ALUout/MDR).
- reg_we  out  1  register-file write enable.
- phase_o  out  3  state code.
- instr_cnt_o  out  CNT_W  retired-instruction count.
- halted_o  out  1  sticky; HALT retired.
- err_o  out  1  sticky; illegal class or timeout.

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IF.
  - All outputs go to 0, including ir_o, instr_cnt_o, halted_o and err_o.
  - Any in-flight request is abandoned; req drops in the cycle after the reset edge.
  - imem_req rises in the first cycle after rst returns high.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6.
- IF:
  - imem_req=1, imem_addr=pc_i.
  - Hold until imem_ack=1; ack in the same cycle as req is legal.
  - On ack: ir_o<=imem_rdata, go to ID, req drops next cycle.
- ID:
  - lat_we=1. Sample cls_i:
    - ALU, LOAD, STORE, BRANCH: go to EX.
    - JUMP: pc_we=1 this cycle, go to IF.
    - JAL: go to WB.
    - HALT: go to HALT.
    - 7: go to ERR.
- EX:
  - lat_we=1.
  - ALU: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: pc_we=1, go to IF.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE, 0 for LOAD.
  - Hold until dmem_ack=1.
  - LOAD: lat_we=1 in the ack cycle, then go to WB.
  - STORE: pc_we=1 in the ack cycle, then go to IF.
- WB: reg_we=1, pc_we=1, go to IF.
- The class is latched in ID and held through the instruction; cls_i is ignored outside ID.
- Zero-wait latencies (cycles per instruction): ALU 4, LOAD 5, STORE 4, BRANCH 3, JUMP 2, JAL 3.
- Each wait cycle adds one cycle.
- pc_we is exactly one pulse per retired instruction.
- instr_cnt_o increments on each pc_we and wraps from 2^CNT_W-1 to 0.
- HALT and ERR are absorbing until reset: all enables and reqs are 0. halted_o=1 in HALT; err_o=1 in ERR.
- An ack arriving while the matching req is low is ignored.
- Address and dmem_we stay stable while req is high.

Optional Feature:
- Macro MC_SEQ_TIMEOUT_EN.
- Defined: a wait counter runs in IF and MEM while req=1 and ack=0. It clears on ack or state change. When it reaches TO_CYCLES, the FSM goes to ERR and req drops.
- Undefined: waits are unbounded, the counter is not built, and err_o reports illegal class only.

Decomposition:
- Package mc_seq_pkg holds:
  - the state codes;
  - the class codes 0-7;
  - a localparam for the number of states.
- One sub-module, mc_wait_timer: parametrised down-counter with clear, enable and an expire flag. Instantiated only under MC_SEQ_TIMEOUT_EN.

Test Plan:
- Zero-wait ALU, then LOAD, then STORE, with acks in the same cycle as req → pc_we pulses at cycles 4, 9 and 13 after reset release; instr_cnt_o=3; reg_we high for one cycle in each WB.
- LOAD with dmem_ack delayed 3 cycles → dmem_req high for 4 cycles with dmem_we=0; total latency 8 cycles; lat_we high in the ack cycle.
- cls_i=7 in ID → err_o=1 the next cycle; imem_req stays 0; phase_o=6 until rst is low.
- rst low during a MEM wait → dmem_req=0 the next cycle; all outputs 0; imem_req=1 in the first cycle after rst goes high.
- With MC_SEQ_TIMEOUT_EN and TO_CYCLES=4, imem_ack never asserted → ERR after 4 wait cycles. Without the macro → still IF after 1000 cycles.
- instr_cnt_o preset near wrap (CNT_W=4): 17 JUMPs → instr_cnt_o=1; a HALT afterwards sets halted_o=1 and the count stays frozen.

Source files
------------

// File: rtl/mc_seq_pkg.sv
// Shared codes for the multicycle bus sequencer: phase/state codes, decoder
// instruction classes and a small class helper.
package mc_seq_pkg;

    localparam int unsigned NUM_STATES = 7;
    localparam int unsigned STATE_W    = $clog2(NUM_STATES);

    typedef enum logic [STATE_W-1:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_HALT   = 3'd6,
        CLS_ILL    = 3'd7
    } cls_e;

    function automatic logic is_mem_cls(input cls_e c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Down-counting wait timer: reloads on clear, counts while enabled and flags
// the cycle in which the LIMIT-th consecutive enabled cycle occurs.
module mc_wait_timer #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_r;

    // Remaining wait budget; saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= W'(LIMIT);
        end else if (clr) begin
            cnt_r <= W'(LIMIT);
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = en && !clr && (cnt_r == W'(1));

endmodule

// File: rtl/mc_bus_sequencer.sv
// Multicycle IF/ID/EX/MEM/WB phase sequencer with req/ack memory handshakes.
// Optional wait timeout is built only when MC_SEQ_TIMEOUT_EN is defined.
module mc_bus_sequencer
    import mc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TO_CYCLES = 255,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cls_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] ir_o,
    output logic              pc_we,
    output logic              lat_we,
    output logic              reg_we,
    output logic [2:0]        phase_o,
    output logic [CNT_W-1:0]  instr_cnt_o,
    output logic              halted_o,
    output logic              err_o
);

    state_e state_r;
    state_e state_s;
    cls_e   cls_r;
    cls_e   cls_in_s;
    logic   run_r;
    logic   fetch_done_s;
    logic   mem_done_s;
    logic   timeout_s;

    assign cls_in_s     = cls_e'(cls_i);
    // Acks only count while the matching request is actually up.
    assign fetch_done_s = imem_req && imem_ack;
    assign mem_done_s   = dmem_req && dmem_ack;

`ifdef MC_SEQ_TIMEOUT_EN
    logic wait_s;
    assign wait_s = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);

    mc_wait_timer #(
        .LIMIT (TO_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!wait_s),
        .en      (wait_s),
        .expired (timeout_s)
    );
`else
    logic unused_to_s;
    assign unused_to_s = (TO_CYCLES == 32'd0);
    assign timeout_s   = 1'b0;
`endif

    // State register; run_r keeps every request low while reset is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IF;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            run_r   <= 1'b1;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IF: begin
                if (fetch_done_s)   state_s = ST_ID;
                else if (timeout_s) state_s = ST_ERR;
                else                state_s = ST_IF;
            end
            ST_ID: begin
                case (cls_in_s)
                    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: state_s = ST_EX;
                    CLS_JUMP: state_s = ST_IF;
                    CLS_JAL:  state_s = ST_WB;
                    CLS_HALT: state_s = ST_HALT;
                    default:  state_s = ST_ERR;
                endcase
            end
            ST_EX: begin
                if (cls_r == CLS_ALU)         state_s = ST_WB;
                else if (is_mem_cls(cls_r))   state_s = ST_MEM;
                else if (cls_r == CLS_BRANCH) state_s = ST_IF;
                else                          state_s = ST_ERR;
            end
            ST_MEM: begin
                if (mem_done_s)     state_s = (cls_r == CLS_LOAD) ? ST_WB : ST_IF;
                else if (timeout_s) state_s = ST_ERR;
                else                state_s = ST_MEM;
            end
            ST_WB:   state_s = ST_IF;
            ST_HALT: state_s = ST_HALT;
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_ERR;
        endcase
    end

    // Output decode; HALT and ERR leave every enable and request low.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        lat_we   = 1'b0;
        reg_we   = 1'b0;
        case (state_r)
            ST_IF: begin
                imem_req = run_r;
            end
            ST_ID: begin
                lat_we = 1'b1;
                pc_we  = (cls_in_s == CLS_JUMP);
            end
            ST_EX: begin
                lat_we = 1'b1;
                pc_we  = (cls_r == CLS_BRANCH);
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_r == CLS_STORE);
                lat_we   = dmem_ack && (cls_r == CLS_LOAD);
                pc_we    = dmem_ack && (cls_r == CLS_STORE);
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign imem_addr = imem_req ? pc_i : {ADDR_W{1'b0}};
    assign phase_o   = state_r;
    assign halted_o  = (state_r == ST_HALT);
    assign err_o     = (state_r == ST_ERR);

    // Instruction register, latched class and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_o        <= {DATA_W{1'b0}};
            cls_r       <= CLS_ALU;
            instr_cnt_o <= {CNT_W{1'b0}};
        end else begin
            if (fetch_done_s) ir_o <= imem_rdata;
            else              ir_o <= ir_o;
            if (state_r == ST_ID) cls_r <= cls_in_s;
            else                  cls_r <= cls_r;
            if (pc_we) instr_cnt_o <= instr_cnt_o + CNT_W'(1);
            else       instr_cnt_o <= instr_cnt_o;
        end
    end

endmodule

// File: tb/tb_mc_bus_sequencer.sv
// Directed self-checking bench for mc_bus_sequencer (CNT_W=4, TO_CYCLES=4);
// the timeout check follows MC_SEQ_TIMEOUT_EN.
module tb_mc_bus_sequencer;

    logic        clk;
    logic        rst;
    logic [2:0]  cls_i;
    logic [31:0] pc_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] ir_o;
    logic        pc_we;
    logic        lat_we;
    logic        reg_we;
    logic [2:0]  phase_o;
    logic [3:0]  instr_cnt_o;
    logic        halted_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    // ALU, LOAD, STORE, BRANCH, JAL back to back with zero-wait acks.
    int t1_cls [19] = '{0,0,0,0, 1,1,1,1,1, 2,2,2,2, 3,3,3, 5,5,5};
    int t1_ph  [19] = '{0,1,2,4, 0,1,2,3,4, 0,1,2,3, 0,1,2, 0,1,4};
    int t1_pc  [19] = '{0,0,0,1, 0,0,0,0,1, 0,0,0,1, 0,0,1, 0,0,1};
    int t1_rw  [19] = '{0,0,0,1, 0,0,0,0,1, 0,0,0,0, 0,0,0, 0,0,1};
    int t1_lw  [19] = '{0,1,1,0, 0,1,1,1,0, 0,1,1,0, 0,1,1, 0,1,0};
    // LOAD whose data ack arrives in the fourth MEM cycle.
    int t2_ph  [8]  = '{0,1,2,3,3,3,3,4};
    int t2_lw  [8]  = '{0,1,1,0,0,0,1,0};
    int t2_pc  [8]  = '{0,0,0,0,0,0,0,1};

    mc_bus_sequencer #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .TO_CYCLES (4),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cls_i       (cls_i),
        .pc_i        (pc_i),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .ir_o        (ir_o),
        .pc_we       (pc_we),
        .lat_we      (lat_we),
        .reg_we      (reg_we),
        .phase_o     (phase_o),
        .instr_cnt_o (instr_cnt_o),
        .halted_o    (halted_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) begin
            cyc();
            #1;
            check_eq("rst_outs", 64'({ir_o, instr_cnt_o, phase_o, imem_req, dmem_req, dmem_we,
                                      pc_we, lat_we, reg_we, halted_o, err_o}), 64'd0);
            check_eq("rst_addr", 64'(imem_addr), 64'd0);
        end
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        cls_i      = 3'd0;
        pc_i       = 32'h0000_0100;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        dmem_ack   = 1'b0;

        // Zero-wait mix of classes.
        do_reset();
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int i = 0; i < 19; i++) begin
            cyc();
            cls_i      = 3'(t1_cls[i]);
            imem_rdata = 32'hC0DE_0000 + 32'(t1_cls[i]);
            #1;
            check_eq($sformatf("t1_phase[%0d]", i), 64'(phase_o), 64'(t1_ph[i]));
            check_eq($sformatf("t1_pc_we[%0d]", i), 64'(pc_we), 64'(t1_pc[i]));
            check_eq($sformatf("t1_reg_we[%0d]", i), 64'(reg_we), 64'(t1_rw[i]));
            check_eq($sformatf("t1_lat_we[%0d]", i), 64'(lat_we), 64'(t1_lw[i]));
            check_eq($sformatf("t1_imem_req[%0d]", i), 64'(imem_req), 64'(t1_ph[i] == 0));
            check_eq($sformatf("t1_dmem_req[%0d]", i), 64'(dmem_req), 64'(t1_ph[i] == 3));
            if (t1_ph[i] == 0)
                check_eq($sformatf("t1_addr[%0d]", i), 64'(imem_addr), 64'h0000_0100);
            if (t1_ph[i] == 3)
                check_eq($sformatf("t1_dmem_we[%0d]", i), 64'(dmem_we), 64'(t1_cls[i] == 2));
            if (t1_ph[i] == 1)
                check_eq($sformatf("t1_ir[%0d]", i), 64'(ir_o), 64'(32'hC0DE_0000 + 32'(t1_cls[i])));
        end
        cyc();
        #1;
        check_eq("t1_cnt", 64'(instr_cnt_o), 64'd5);

        // LOAD with a delayed data ack; the early ack in ID must be ignored.
        do_reset();
        cls_i = 3'd1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            dmem_ack = (i == 1) || (i == 6);
            #1;
            check_eq($sformatf("t2_phase[%0d]", i), 64'(phase_o), 64'(t2_ph[i]));
            check_eq($sformatf("t2_lat_we[%0d]", i), 64'(lat_we), 64'(t2_lw[i]));
            check_eq($sformatf("t2_pc_we[%0d]", i), 64'(pc_we), 64'(t2_pc[i]));
            check_eq($sformatf("t2_dmem_req[%0d]", i), 64'(dmem_req), 64'(t2_ph[i] == 3));
            if (t2_ph[i] == 3)
                check_eq($sformatf("t2_dmem_we[%0d]", i), 64'(dmem_we), 64'd0);
        end
        cyc();
        dmem_ack = 1'b0;
        #1;
        check_eq("t2_phase_end", 64'(phase_o), 64'd0);
        check_eq("t2_cnt", 64'(instr_cnt_o), 64'd1);

        // Illegal class is absorbing.
        do_reset();
        cls_i = 3'd7;
        for (int i = 0; i < 8; i++) begin
            cyc();
            #1;
            check_eq($sformatf("t3_phase[%0d]", i), 64'(phase_o), (i < 2) ? 64'(i) : 64'd6);
            check_eq($sformatf("t3_err[%0d]", i), 64'(err_o), 64'(i >= 2));
            check_eq($sformatf("t3_imem_req[%0d]", i), 64'(imem_req), 64'(i == 0));
            check_eq($sformatf("t3_pc_we[%0d]", i), 64'(pc_we), 64'd0);
        end
        check_eq("t3_cnt", 64'(instr_cnt_o), 64'd0);

        // Reset in the middle of a STORE data wait.
        do_reset();
        cls_i = 3'd2;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            if (i >= 3) begin
                check_eq($sformatf("t4_dmem_req[%0d]", i), 64'(dmem_req), 64'd1);
                check_eq($sformatf("t4_dmem_we[%0d]", i), 64'(dmem_we), 64'd1);
                check_eq($sformatf("t4_phase[%0d]", i), 64'(phase_o), 64'd3);
            end
        end
        do_reset();
        cyc();
        #1;
        check_eq("t4_req_after_rst", 64'(imem_req), 64'd1);
        check_eq("t4_phase_after_rst", 64'(phase_o), 64'd0);

        // Fetch ack never arrives.
        do_reset();
        imem_ack = 1'b0;
`ifdef MC_SEQ_TIMEOUT_EN
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            check_eq($sformatf("t5_phase[%0d]", i), 64'(phase_o), (i < 4) ? 64'd0 : 64'd6);
            check_eq($sformatf("t5_imem_req[%0d]", i), 64'(imem_req), 64'(i < 4));
            check_eq($sformatf("t5_err[%0d]", i), 64'(err_o), 64'(i == 4));
        end
`else
        repeat (1000) cyc();
        #1;
        check_eq("t5_phase", 64'(phase_o), 64'd0);
        check_eq("t5_imem_req", 64'(imem_req), 64'd1);
        check_eq("t5_err", 64'(err_o), 64'd0);
`endif

        // 17 JUMPs wrap the 4-bit counter to 1, then HALT freezes it.
        do_reset();
        imem_ack = 1'b1;
        cls_i    = 3'd4;
        for (int i = 0; i < 34; i++) begin
            cyc();
            #1;
            check_eq($sformatf("t6_pc_we[%0d]", i), 64'(pc_we), 64'(i % 2 == 1));
            check_eq($sformatf("t6_phase[%0d]", i), 64'(phase_o), 64'(i % 2));
        end
        cyc();
        cls_i = 3'd6;
        #1;
        check_eq("t6_cnt_wrap", 64'(instr_cnt_o), 64'd1);
        cyc();
        #1;
        check_eq("t6_halt_id_pc_we", 64'(pc_we), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            check_eq($sformatf("t6_halted[%0d]", i), 64'(halted_o), 64'd1);
            check_eq($sformatf("t6_hphase[%0d]", i), 64'(phase_o), 64'd5);
            check_eq($sformatf("t6_henables[%0d]", i),
                     64'({imem_req, dmem_req, pc_we, lat_we, reg_we}), 64'd0);
            check_eq($sformatf("t6_hcnt[%0d]", i), 64'(instr_cnt_o), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
